// File: rtl/scrambler_64b66b_tx.sv
// rtl/scrambler_64b66b_tx.sv - 64b/66b self-synchronous tx scrambler (1 + x^39 + x^58)
// with a registered output stage and 2-entry skid buffer; the sync header bypasses scrambling.
module scrambler_64b66b_tx #(
  parameter int LEN = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [1:0]     head_i,
  input  logic [LEN-1:0] data_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [1:0]     head_o,
  output logic [LEN-1:0] scram_o
);

  localparam int SW = 58;

  // state_q encodes {valid_o, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_next;
  logic [LEN+SW-1:0] seq;
  logic [LEN-1:0]    sc, skid_data;
  logic [1:0]        skid_head;
  logic              ready_q, in_xfer, out_xfer;
  logic              load_main, load_skid, move_skid;

  // History (oldest first) followed by the new scrambled bits in transmission order,
  // so each new bit simply taps the bits 39 and 58 positions behind it.
  function automatic logic [LEN+SW-1:0] scramble_seq(input logic [LEN-1:0] d,
                                                     input logic [SW-1:0]  s);
    logic [LEN+SW-1:0] q;
    q = '0;
    for (int k = 0; k < SW; k++) q[SW-1-k] = s[k];
    for (int i = 0; i < LEN; i++) q[SW+i] = d[i] ^ q[SW-39+i] ^ q[i];
    return q;
  endfunction

  assign ready_o  = ready_q & ~reset;
  assign valid_o  = state_q[1];
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    s_next = s_q;
    seq    = scramble_seq(data_i, s_q);
    sc     = seq[LEN+SW-1:SW];
    for (int k = 0; k < SW; k++) s_next[k] = seq[LEN+SW-1-k];
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = FULL;
          load_main = 1'b1;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = SKID;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_xfer) begin
          state_d   = FULL;
          move_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      ready_q   <= 1'b1;
      s_q       <= '1;
      head_o    <= '0;
      scram_o   <= '0;
      skid_head <= '0;
      skid_data <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ~state_d[0];
      if (in_xfer) s_q <= s_next;
      if (load_main) begin
        head_o  <= head_i;
        scram_o <= sc;
      end else if (move_skid) begin
        head_o  <= skid_head;
        scram_o <= skid_data;
      end
      if (load_skid) begin
        skid_head <= head_i;
        skid_data <= sc;
      end
    end
  end

endmodule

// File: tb/tb_scrambler_64b66b_tx.sv
// tb/tb_scrambler_64b66b_tx.sv - self-checking bench for scrambler_64b66b_tx at LEN 64, 32 and 264
module tb_scrambler_64b66b_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         vi[3], ri[3], vo[3], ro[3];
  logic [1:0]   hi[3], ho[3];
  logic [263:0] di[3], so[3];

  logic         vo_64, ro_64, vo_32, ro_32, vo_264, ro_264;
  logic [1:0]   ho_64, ho_32, ho_264;
  logic [63:0]  so_64;
  logic [31:0]  so_32;
  logic [263:0] so_264;

  scrambler_64b66b_tx #(.LEN(64)) dut_64 (
    .clk(clk), .reset(reset), .valid_i(vi[0]), .ready_o(ro_64), .head_i(hi[0]),
    .data_i(di[0][63:0]), .valid_o(vo_64), .ready_i(ri[0]), .head_o(ho_64), .scram_o(so_64));
  scrambler_64b66b_tx #(.LEN(32)) dut_32 (
    .clk(clk), .reset(reset), .valid_i(vi[1]), .ready_o(ro_32), .head_i(hi[1]),
    .data_i(di[1][31:0]), .valid_o(vo_32), .ready_i(ri[1]), .head_o(ho_32), .scram_o(so_32));
  scrambler_64b66b_tx #(.LEN(264)) dut_264 (
    .clk(clk), .reset(reset), .valid_i(vi[2]), .ready_o(ro_264), .head_i(hi[2]),
    .data_i(di[2]), .valid_o(vo_264), .ready_i(ri[2]), .head_o(ho_264), .scram_o(so_264));

  always_comb begin
    vo[0] = vo_64;  ro[0] = ro_64;  ho[0] = ho_64;  so[0] = 264'(so_64);
    vo[1] = vo_32;  ro[1] = ro_32;  ho[1] = ho_32;  so[1] = 264'(so_32);
    vo[2] = vo_264; ro[2] = ro_264; ho[2] = ho_264; so[2] = so_264;
  end

  int lens[3];
  int n_cmp = 0;
  int n_bad = 0;

  // Bit-serial reference: history bit 0 is the most recent transmitted bit.
  logic [57:0]  tx_hist[3], rx_hist[3];
  logic [263:0] sb_sc[3][8], sb_data[3][8];
  logic [1:0]   sb_head[3][8];
  int           wr[3], rd[3];
  logic         hold[3];
  logic [265:0] held[3];

  typedef struct {
    logic [1:0]  head;
    logic [63:0] data;
    logic [1:0]  exp_head;
    logic [63:0] exp_sc;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [263:0] tx_model(input int k, input logic [263:0] d);
    logic [263:0] o;
    logic b;
    o = '0;
    for (int i = 0; i < lens[k]; i++) begin
      b = d[i] ^ tx_hist[k][38] ^ tx_hist[k][57];
      o[i] = b;
      tx_hist[k] = {tx_hist[k][56:0], b};
    end
    return o;
  endfunction

  function automatic logic [263:0] rx_model(input int k, input logic [263:0] s);
    logic [263:0] o;
    o = '0;
    for (int i = 0; i < lens[k]; i++) begin
      o[i] = s[i] ^ rx_hist[k][38] ^ rx_hist[k][57];
      rx_hist[k] = {rx_hist[k][56:0], s[i]};
    end
    return o;
  endfunction

  function automatic logic [263:0] rand_data(input int len);
    logic [263:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vi[k] = 1'b0;
      ri[k] = 1'b0;
    end
    repeat (cycles) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_L%0d", lens[k]), 272'(vo[k]), 272'(0));
      check($sformatf("rst_ready_L%0d", lens[k]), 272'(ro[k]), 272'(0));
      check($sformatf("rst_out_L%0d", lens[k]), {ho[k], so[k]}, 272'(0));
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_rst_ready_L%0d", lens[k]), 272'(ro[k]), 272'(1));
      tx_hist[k] = '1;
      rx_hist[k] = '1;
      wr[k] = 0;
      rd[k] = 0;
      hold[k] = 1'b0;
    end
  endtask

  task automatic rand_step(input int k);
    int occ;
    occ = wr[k] - rd[k];
    check($sformatf("valid_vs_occ_L%0d", lens[k]), 272'(vo[k]), 272'(occ != 0));
    check($sformatf("ready_vs_occ_L%0d", lens[k]), 272'(ro[k]), 272'(occ < 2));
    if (hold[k]) check($sformatf("stall_hold_L%0d", lens[k]), {ho[k], so[k]}, 272'(held[k]));
    vi[k] = ($urandom_range(0, 9) < 7);
    ri[k] = ($urandom_range(0, 9) < 7);
    hi[k] = 2'($urandom);
    di[k] = rand_data(lens[k]);
    if (vi[k] && ro[k]) begin
      sb_head[k][wr[k] % 8] = hi[k];
      sb_data[k][wr[k] % 8] = di[k];
      sb_sc[k][wr[k] % 8]   = tx_model(k, di[k]);
      wr[k]++;
    end
    if (vo[k] && ri[k] && occ > 0) begin
      check($sformatf("tx_out_L%0d", lens[k]), {ho[k], so[k]},
            {sb_head[k][rd[k] % 8], sb_sc[k][rd[k] % 8]});
      check($sformatf("loopback_L%0d", lens[k]), 272'(rx_model(k, so[k])),
            272'(sb_data[k][rd[k] % 8]));
      rd[k]++;
    end
    hold[k] = vo[k] && !ri[k];
    held[k] = {ho[k], so[k]};
  endtask

  initial begin
    int acc;
    logic [1:0]   bp_h[2];
    logic [263:0] bp_d[2];
    logic [263:0] junk;

    lens[0] = 64;
    lens[1] = 32;
    lens[2] = 264;
    for (int k = 0; k < 3; k++) begin
      hi[k] = '0;
      di[k] = '0;
    end
    do_reset(2);

    // Table: first two expectations worked out by hand from an all-ones state, the rest by the model.
    vecs[0].head = 2'b01; vecs[0].data = 64'h0; vecs[0].exp_head = 2'b01;
    vecs[0].exp_sc = 64'h03FF_FF80_0000_0000;
    vecs[1].head = 2'b10; vecs[1].data = 64'h0; vecs[1].exp_head = 2'b10;
    vecs[1].exp_sc = 64'hFFEF_FFFF_FFFF_C000;
    junk = tx_model(0, 264'(vecs[0].data));
    junk = tx_model(0, 264'(vecs[1].data));
    for (int j = 2; j < 6; j++) begin
      vecs[j].head     = 2'(j);
      vecs[j].data     = {$urandom, $urandom};
      vecs[j].exp_head = vecs[j].head;
      junk             = tx_model(0, 264'(vecs[j].data));
      vecs[j].exp_sc   = junk[63:0];
    end

    ri[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      vi[0] = 1'b1;
      hi[0] = vecs[j].head;
      di[0] = 264'(vecs[j].data);
      @(negedge clk);
      check($sformatf("vec%0d_valid", j), 272'(vo[0]), 272'(1));
      check($sformatf("vec%0d_out", j), {ho[0], so[0]}, {vecs[j].exp_head, 264'(vecs[j].exp_sc)});
    end
    vi[0] = 1'b0;
    @(negedge clk);
    check("vec_drained", 272'(vo[0]), 272'(0));

    // Back-pressure: 5 cycles of valid_i with ready_i low
    do_reset(1);
    acc = 0;
    ri[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vi[0] = 1'b1;
      hi[0] = 2'($urandom);
      di[0] = rand_data(64);
      if (ro[0]) begin
        if (acc < 2) begin
          bp_h[acc] = hi[0];
          bp_d[acc] = tx_model(0, di[0]);
        end
        acc++;
      end
      @(negedge clk);
    end
    check("bp_accepted", 272'(acc), 272'(2));
    check("bp_ready_low", 272'(ro[0]), 272'(0));
    vi[0] = 1'b0;
    ri[0] = 1'b1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("bp_valid%0d", j), 272'(vo[0]), 272'(1));
      check($sformatf("bp_out%0d", j), {ho[0], so[0]}, {bp_h[j], bp_d[j]});
      @(negedge clk);
    end
    check("bp_ready_back", 272'(ro[0]), 272'(1));
    check("bp_empty", 272'(vo[0]), 272'(0));

    // Reset with the skid full, then replay the first vector
    ri[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vi[0] = 1'b1;
      hi[0] = 2'b11;
      di[0] = rand_data(64);
      @(negedge clk);
    end
    check("skid_full_ready", 272'(ro[0]), 272'(0));
    do_reset(1);
    check("midrst_valid", 272'(vo[0]), 272'(0));
    ri[0] = 1'b1;
    vi[0] = 1'b1;
    hi[0] = vecs[0].head;
    di[0] = 264'(vecs[0].data);
    @(negedge clk);
    vi[0] = 1'b0;
    check("replay_out", {ho[0], so[0]}, {2'b01, 264'(64'h03FF_FF80_0000_0000)});

    // Random traffic with bubbles and stalls on all three widths
    do_reset(2);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int k = 0; k < 3; k++) rand_step(k);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) vi[k] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scrambler_64b66b_tx.md
# scrambler_64b66b_tx

Self-synchronous 64b/66b scrambler for the transmit path, polynomial G(x) = 1 + x^39 + x^58. It sits between the 64b/66b encoder and the gearbox. It scrambles the block payload and passes the 2-bit sync header through unscrambled and aligned with its payload. It has a registered output stage with a 2-entry skid buffer, so it tolerates back-pressure without a combinational ready path. Its output is bit-exact with the rx descrambler when both start from reset.

## Interface
- LEN, 64: payload bits per transfer; any value ≥ 1 (64 = one block, 264 etc. supported).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  input payload valid.
- ready_o  out  1  block can accept; registered.
- head_i  in  2  sync header accompanying data_i, not scrambled.
- data_i  in  LEN  unscrambled payload; bit 0 is transmitted first.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream accepts.
- head_o  out  2  sync header, aligned with scram_o.
- scram_o  out  LEN  scrambled payload.

## Operation
- Input transfer: valid_i & ready_o & ~reset. Output transfer: valid_o & ready_i.
- Scrambler state s_q[57:0] holds the last 58 scrambled bits; s_q[0] is the most recently produced bit.
- s_q resets to all ones.
- Scrambled bit i is combinational on data_i and s_q:
  - sc[i] = data_i[i] ^ A ^ B.
  - A = s_q[38-i] when i ≤ 38, else sc[i-39].
  - B = s_q[57-i] when i ≤ 57, else sc[i-58].
- State update on input transfer only:
  - s_next[k] = sc[LEN-1-k] for k < LEN.
  - s_next[k] = s_q[k-LEN] for k ≥ LEN.
  - Without an input transfer, s_q holds.
- Datapath storage: main output register (valid_o, head_o, scram_o) plus a skid register (skid_v, skid_head, skid_data).
  - Input transfer with output register empty or being drained: sc and head_i are written to the main register.
  - Input transfer while the main register is full and not drained: sc and head_i are written to the skid register.
  - Output transfer while skid_v is set: the skid contents move into the main register, and skid_v clears.
- ready_o = ~skid_v (registered), and it is held low while reset is high.
- States, as {valid_o, skid_v}:
  - EMPTY (0,0) → FULL on an input transfer.
  - FULL (1,0) → EMPTY on an output transfer without an input transfer. Stays FULL on both transfers together. → SKID on an input transfer without an output transfer.
  - SKID (1,1) → FULL on an output transfer (no input is possible in SKID).
- Order is strictly FIFO. No block is dropped or duplicated, and scrambler state order equals output order.
- head_i values are not checked; 2'b00 and 2'b11 pass through unchanged.

## Timing
- Reset (synchronous, takes effect at the clk edge):
  - valid_o=0, skid_v=0, s_q=all ones.
  - head_o and scram_o are 0.
  - ready_o=0 while reset is high, and 1 in the first cycle after reset is low.
- Reset mid-operation: pending output and skid data are discarded and state returns to all ones. The first block after reset scrambles exactly as after power-up.
- Latency: an input transfer at edge n gives valid_o=1 from edge n, visible in cycle n+1.
- Sustained throughput is 1 transfer/cycle while ready_i=1.
- valid_o, head_o and scram_o are stable while valid_o & ~ready_i.
- ready_o falls the cycle after the skid fills, and rises the cycle after the skid drains.
- Simultaneous input and output transfer in FULL keeps FULL, with the new data in the main register.

## Test plan
- Reset, then data_i=0 and head_i=2'b01 with ready_i=1 and LEN=64 → first scram_o=64'h03FF_FF80_0000_0000 and head_o=2'b01, one cycle after acceptance.
- Loopback: 10k random blocks with random head, fed into the rx descrambler (LEN equal on both sides, both reset together) → recovered data equals data_i for every block from the first; headers match in order.
- Back-pressure: continuous valid_i while ready_i=0 for 5 cycles.
  - Exactly 2 blocks are accepted, and ready_o=0 from the cycle after the second.
  - With ready_i=1 afterwards, blocks exit in order with no gaps and no loss.
- Bubble: valid_i=0 for 3 cycles between blocks → s_q does not change, and output equals a gap-free reference stream.
- Reset mid-stream with the skid full → the cycle after reset valid_o=0 and ready_o=1. A replay of the first test vector gives 64'h03FF_FF80_0000_0000.
- LEN=264 and LEN=32: random loopback against the descrambler with the same LEN → bit-exact match, including the state-shift path for LEN < 58.
